// File: rtl/pipa_moding_pkg.sv
// Shared constants and types for the PIPA moding generator.
// Axis indices, the legacy 3-3 default counts and the plus/minus config record.
package pipa_moding_pkg;

  localparam int AXIS_X = 0;
  localparam int AXIS_Y = 1;
  localparam int AXIS_Z = 2;

  localparam int MODING_CNT_W  = 3;
  localparam int DEF_PLUS_CNT  = 3;
  localparam int DEF_MINUS_CNT = 3;

  typedef struct packed {
    logic [MODING_CNT_W-1:0] plus;
    logic [MODING_CNT_W-1:0] minus;
  } moding_cfg_t;

  localparam moding_cfg_t DEF_CFG = '{plus:  MODING_CNT_W'(DEF_PLUS_CNT),
                                      minus: MODING_CNT_W'(DEF_MINUS_CNT)};

endpackage

// File: rtl/pipa_axis_phase.sv
// One PIPA axis: active/shadow moding ratio, pending flag, phase counter
// and the plus/minus select derived from them.
module pipa_axis_phase
  import pipa_moding_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int DEF_PLUS  = DEF_PLUS_CNT,
  parameter int DEF_MINUS = DEF_MINUS_CNT
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             sw_rise,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_plus,
  input  logic [CNT_W-1:0] wr_minus,
  output logic             pending,
  output logic             plus_sel,
  output logic             minus_sel
);

  logic [CNT_W-1:0] act_plus_reg;
  logic [CNT_W-1:0] act_minus_reg;
  logic [CNT_W-1:0] shd_plus_reg;
  logic [CNT_W-1:0] shd_minus_reg;
  logic             pending_reg;
  logic [CNT_W:0]   phase_reg;
  logic [CNT_W:0]   len;

  // One extra bit so the largest plus+minus sum cannot wrap.
  assign len = {1'b0, act_plus_reg} + {1'b0, act_minus_reg};

  // Phase stepping, shadow adoption and shadow writes. The write is placed
  // after the adoption so a coincident write re-arms pending, while the
  // adoption still copies the shadow value held before this edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      act_plus_reg  <= CNT_W'(DEF_PLUS);
      act_minus_reg <= CNT_W'(DEF_MINUS);
      shd_plus_reg  <= CNT_W'(DEF_PLUS);
      shd_minus_reg <= CNT_W'(DEF_MINUS);
      pending_reg   <= 1'b0;
      phase_reg     <= '0;
    end else begin
      if (sw_rise) begin
        if (pending_reg) begin
          act_plus_reg  <= shd_plus_reg;
          act_minus_reg <= shd_minus_reg;
          phase_reg     <= '0;
          pending_reg   <= 1'b0;
        end else if (len == '0) begin
          phase_reg <= '0;
        end else begin
          phase_reg <= (phase_reg == len - 1'b1) ? '0 : phase_reg + 1'b1;
        end
      end
      if (wr_en) begin
        shd_plus_reg  <= wr_plus;
        shd_minus_reg <= wr_minus;
        pending_reg   <= 1'b1;
      end
    end
  end

  // Plus for the first active_plus phases, minus for the rest; silent at 0/0.
  always_comb begin
    plus_sel  = (len != '0) && (phase_reg < {1'b0, act_plus_reg});
    minus_sel = (len != '0) && !plus_sel;
  end

  assign pending = pending_reg;

endmodule

// File: rtl/pipa_moding_gen.sv
// PIPA moding generator: per-axis plus/minus pulse trains gated by PIPDAT and
// stepped by rising edges of PIPASW, all on SIM_CLK.
// Optional build macro PIPA_NET_COUNT_EN adds per-axis signed net pulse
// counters (net_count) with a clear input (cnt_clr).
module pipa_moding_gen
  import pipa_moding_pkg::*;
#(
  parameter int NUM_AXES  = 3,
  parameter int CNT_W     = 3,
  parameter int DEF_PLUS  = DEF_PLUS_CNT,
  parameter int DEF_MINUS = DEF_MINUS_CNT,
  parameter int AXIS_W    = 2
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                PIPASW,
  input  logic                PIPDAT,
  input  logic                cfg_we,
  input  logic [AXIS_W-1:0]   cfg_axis,
  input  logic [CNT_W-1:0]    cfg_plus,
  input  logic [CNT_W-1:0]    cfg_minus,
  output logic [NUM_AXES-1:0] cfg_pending,
  output logic [NUM_AXES-1:0] PIPAp,
  output logic [NUM_AXES-1:0] PIPAm
`ifdef PIPA_NET_COUNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [NUM_AXES*16-1:0] net_count
`endif
);

  logic                sw_q_reg;
  logic                sw_rise;
  logic [NUM_AXES-1:0] plus_sel;
  logic [NUM_AXES-1:0] minus_sel;

  // PIPASW edge detector; the phase logic runs on SIM_CLK only.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      sw_q_reg <= 1'b0;
    end else begin
      sw_q_reg <= PIPASW;
    end
  end

  assign sw_rise = PIPASW & ~sw_q_reg;

  // Config demux: an axis index with no matching instance selects nothing,
  // so out-of-range writes leave every axis untouched.
  for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
    logic wr_en;
    assign wr_en = cfg_we && (cfg_axis == AXIS_W'(gi));

    pipa_axis_phase #(
      .CNT_W    (CNT_W),
      .DEF_PLUS (DEF_PLUS),
      .DEF_MINUS(DEF_MINUS)
    ) u_axis (
      .clk      (SIM_CLK),
      .srst     (SIM_RST),
      .sw_rise  (sw_rise),
      .wr_en    (wr_en),
      .wr_plus  (cfg_plus),
      .wr_minus (cfg_minus),
      .pending  (cfg_pending[gi]),
      .plus_sel (plus_sel[gi]),
      .minus_sel(minus_sel[gi])
    );

    // PIPDAT passes straight through so the pulse has no added latency.
    assign PIPAp[gi] = PIPDAT & plus_sel[gi]  & ~SIM_RST;
    assign PIPAm[gi] = PIPDAT & minus_sel[gi] & ~SIM_RST;
  end

`ifdef PIPA_NET_COUNT_EN
  logic pd_q_reg;
  logic pd_rise;

  // PIPDAT edge detector for the net counters.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      pd_q_reg <= 1'b0;
    end else begin
      pd_q_reg <= PIPDAT;
    end
  end

  assign pd_rise = PIPDAT & ~pd_q_reg;

  for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_cnt
    logic [15:0] cnt_reg;

    // Signed net pulse count, wrapping; clear beats a coincident pulse.
    always_ff @(posedge SIM_CLK) begin
      if (SIM_RST || cnt_clr) begin
        cnt_reg <= '0;
      end else if (pd_rise) begin
        if (plus_sel[gi]) begin
          cnt_reg <= cnt_reg + 16'd1;
        end else if (minus_sel[gi]) begin
          cnt_reg <= cnt_reg - 16'd1;
        end
      end
    end

    assign net_count[gi*16 +: 16] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_pipa_moding_gen.sv
// Directed, table-driven bench for pipa_moding_gen with hand-computed
// expectations, plus hand sequences for reset/gating and the net counters.
module tb_pipa_moding_gen;
  import pipa_moding_pkg::*;

  localparam int OP_CHK  = 0;  // check only
  localparam int OP_EDGE = 1;  // one PIPASW period, then check
  localparam int OP_WR   = 2;  // config write, then check
  localparam int OP_WRE  = 3;  // config write coincident with PIPASW rise
  localparam int OP_RST  = 4;  // SIM_RST pulse, then check

  typedef struct {
    int          op;
    logic [1:0]  axis;
    moding_cfg_t cfg;
    logic [2:0]  exp_p;
    logic [2:0]  exp_m;
    logic [2:0]  exp_pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        pipasw = 1'b0;
  logic        pipdat = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_axis = '0;
  logic [2:0]  cfg_plus = '0;
  logic [2:0]  cfg_minus = '0;
  logic [2:0]  cfg_pending;
  logic [2:0]  pipap;
  logic [2:0]  pipam;
`ifdef PIPA_NET_COUNT_EN
  logic        cnt_clr = 1'b0;
  logic [47:0] net_count;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipa_moding_gen dut (
    .SIM_CLK    (clk),
    .SIM_RST    (srst),
    .PIPASW     (pipasw),
    .PIPDAT     (pipdat),
    .cfg_we     (cfg_we),
    .cfg_axis   (cfg_axis),
    .cfg_plus   (cfg_plus),
    .cfg_minus  (cfg_minus),
    .cfg_pending(cfg_pending),
    .PIPAp      (pipap),
    .PIPAm      (pipam)
`ifdef PIPA_NET_COUNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .net_count  (net_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_period();
    pipasw = 1'b1;
    tick();
    pipasw = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int op, input logic [1:0] ax, input logic [2:0] pl,
                     input logic [2:0] mi, input logic [2:0] ep,
                     input logic [2:0] em, input logic [2:0] epd);
    vec_t v;
    v.op = op; v.axis = ax; v.cfg.plus = pl; v.cfg.minus = mi;
    v.exp_p = ep; v.exp_m = em; v.exp_pend = epd;
    vecs.push_back(v);
  endtask

  initial begin
    // Legacy 3-3 out of reset: periods 0-11.
    add(OP_CHK,  0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);   // 12th edge, phase 0
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);   // phase 1
    // Y = 1/4 mid-cycle: pending until next edge, then +,-,-,-,-,+.
    add(OP_WR,   AXIS_Y, 1, 4, 3'b111, 3'b000, 3'b010);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b101, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    // Z = 0/0: silent for 10 periods after adoption.
    add(OP_WR,   AXIS_Z, 0, 0, 3'b111, 3'b000, 3'b100);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b011, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b010, 3'b001, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    // X: 1/1 pending, then 5/2 written on the adopting edge.
    add(OP_WR,   AXIS_X, 1, 1, 3'b001, 3'b010, 3'b001);
    add(OP_WRE,  AXIS_X, 5, 2, 3'b001, 3'b010, 3'b001);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b011, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b011, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b011, 3'b000, 3'b000);
    // Out-of-range axis is ignored.
    add(OP_WR,   2'd3, 7, 7, 3'b011, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b010, 3'b000);
    // Reset discards a pending write; legacy 3-3 resumes.
    add(OP_WR,   AXIS_Y, 7, 7, 3'b001, 3'b010, 3'b010);
    add(OP_RST,  0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    // X = 7/7 (len 14): full cycle and wrap.
    add(OP_WR,   AXIS_X, 7, 7, 3'b000, 3'b111, 3'b001);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b110, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b110, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b110, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b001, 3'b110, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b110, 3'b001, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b110, 3'b001, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b110, 3'b001, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    add(OP_EDGE, 0, 0, 0, 3'b111, 3'b000, 3'b000);

    // Reset state: outputs forced low during reset even with PIPDAT high.
    tick();
    tick();
    pipdat = 1'b1;
    #1;
    chk("rst_p", -1, 16'(pipap), 16'h0);
    chk("rst_m", -1, 16'(pipam), 16'h0);
    chk("rst_pend", -1, 16'(cfg_pending), 16'h0);
    pipdat = 1'b0;
    srst = 1'b0;
    tick();
    // PIPDAT low gates everything off.
    chk("gate_p", -1, 16'(pipap), 16'h0);
    chk("gate_m", -1, 16'(pipam), 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_EDGE: sw_period();
        OP_WR: begin
          cfg_we = 1'b1; cfg_axis = vecs[i].axis;
          cfg_plus = vecs[i].cfg.plus; cfg_minus = vecs[i].cfg.minus;
          tick();
          cfg_we = 1'b0;
        end
        OP_WRE: begin
          cfg_we = 1'b1; cfg_axis = vecs[i].axis;
          cfg_plus = vecs[i].cfg.plus; cfg_minus = vecs[i].cfg.minus;
          pipasw = 1'b1;
          tick();
          cfg_we = 1'b0;
          pipasw = 1'b0;
          tick();
        end
        OP_RST: begin
          srst = 1'b1;
          tick();
          tick();
          srst = 1'b0;
          tick();
        end
        default: ;
      endcase
      pipdat = 1'b1;
      #1;
      chk("pipap", i, 16'(pipap), 16'(vecs[i].exp_p));
      chk("pipam", i, 16'(pipam), 16'(vecs[i].exp_m));
      chk("pending", i, 16'(cfg_pending), 16'(vecs[i].exp_pend));
      $display("vec %0d op=%0d PIPAp=%b PIPAm=%b pending=%b", i, vecs[i].op,
               pipap, pipam, cfg_pending);
      pipdat = 1'b0;
      #1;
    end

`ifdef PIPA_NET_COUNT_EN
    // Net counters: one 3/3 cycle nets to zero, X at 7/0 counts +7, clear wins.
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    chk("cnt_rst", -1, net_count[15:0], 16'h0000);
    for (int k = 0; k < 6; k++) begin
      pipdat = 1'b1; tick(); pipdat = 1'b0; tick();
      sw_period();
    end
    chk("cnt_33", -1, net_count[15:0], 16'h0000);
    cfg_we = 1'b1; cfg_axis = 2'(AXIS_X); cfg_plus = 3'd7; cfg_minus = 3'd0;
    tick();
    cfg_we = 1'b0;
    sw_period();
    for (int k = 0; k < 7; k++) begin
      pipdat = 1'b1; tick(); pipdat = 1'b0; tick();
      sw_period();
    end
    chk("cnt_70", -1, net_count[15:0], 16'h0007);
    cnt_clr = 1'b1; pipdat = 1'b1;
    tick();
    cnt_clr = 1'b0; pipdat = 1'b0;
    tick();
    chk("cnt_clr", -1, net_count[15:0], 16'h0000);
    $display("net_count X=%0d", $signed(net_count[15:0]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
